// File: rtl/vend_pkg.sv
// Shared types for the parametrised vending controller: FSM states and coin codes.
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        REFUND  = 2'd2
    } state_t;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'd0;
    localparam coin_t COIN_ONE  = 2'd1;
    localparam coin_t COIN_TWO  = 2'd2;
    localparam coin_t COIN_BAD  = 2'd3;

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin-acceptor / actuator bundle of the vending controller; the controller takes the slave side.
interface vend_fsm_param_if #(
    parameter int CREDIT_W = 4,
    parameter int CNT_W    = 8
);
    logic [1:0]          coin;
    logic                cancel;
    logic                sell;
    logic                change;
    logic                coin_rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [CNT_W-1:0]    sold_cnt;

    modport master (
        output coin, cancel,
        input  sell, change, coin_rej, busy, credit, sold_cnt
    );

    modport slave (
        input  coin, cancel,
        output sell, change, coin_rej, busy, credit, sold_cnt
    );
endinterface

// File: rtl/vend_change_out.sv
// Loadable down-counter: one registered change pulse per cycle until the loaded amount is paid out.
module vend_change_out #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         change,
    output logic         done
);

    logic [W-1:0] cnt;

    // cnt holds the pulses still owed after the one currently on the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            change <= 1'b0;
        end else if (load) begin
            if (load_val != '0) begin
                cnt    <= load_val - W'(1);
                change <= 1'b1;
            end else begin
                cnt    <= '0;
                change <= 1'b0;
            end
        end else if (cnt != '0) begin
            cnt    <= cnt - W'(1);
            change <= 1'b1;
        end else begin
            change <= 1'b0;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: collects coins up to PRICE, pulses sell, then pays overpayment as change pulses.
// Optional feature macro: VEND_REFUND_EN (cancel refunds the full credit from COLLECT).
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int CNT_W    = 8
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    vend_fsm_param_if.slave bus
);

    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [CNT_W-1:0]    sold_q, sold_nxt;
    logic                sell_q, sell_nxt;
    logic                rej_q, rej_nxt;
    logic                busy_q, busy_nxt;
    logic [CREDIT_W:0]   sum;
    logic                load;
    logic                chg_done;
    logic                chg_pulse;
    logic                cancel_req;

    function automatic logic [CREDIT_W:0] coin_value(input coin_t c);
        case (c)
            COIN_ONE: return (CREDIT_W+1)'(1);
            COIN_TWO: return (CREDIT_W+1)'(2);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef VEND_REFUND_EN
    assign cancel_req = bus.cancel;
`else
    logic unused_cancel;
    assign cancel_req    = 1'b0;
    assign unused_cancel = bus.cancel;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= COLLECT;
            credit_q <= '0;
            sold_q   <= '0;
            sell_q   <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit_q <= credit_nxt;
            sold_q   <= sold_nxt;
            sell_q   <= sell_nxt;
            rej_q    <= rej_nxt;
            busy_q   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_q;
        sold_nxt   = sold_q;
        sell_nxt   = 1'b0;
        rej_nxt    = 1'b0;
        load       = 1'b0;
        sum        = {1'b0, credit_q} + coin_value(bus.coin);
        case (state)
            COLLECT: begin
                // cancel beats a coin arriving in the same cycle; that coin is lost, not refunded
                if (cancel_req) begin
                    rej_nxt = (bus.coin != COIN_NONE);
                    if (credit_q != '0) begin
                        state_nxt  = REFUND;
                        load       = 1'b1;
                        credit_nxt = credit_q - CREDIT_W'(1);
                    end
                end else if (bus.coin == COIN_BAD) begin
                    rej_nxt = 1'b1;
                end else if (bus.coin != COIN_NONE) begin
                    if (sum >= PRICE_W) begin
                        credit_nxt = CREDIT_W'(sum - PRICE_W);
                        sold_nxt   = sat_inc(sold_q);
                        sell_nxt   = 1'b1;
                        state_nxt  = VEND;
                    end else begin
                        credit_nxt = sum[CREDIT_W-1:0];
                    end
                end
            end
            VEND: begin
                rej_nxt = (bus.coin != COIN_NONE);
                if (credit_q != '0) begin
                    state_nxt  = REFUND;
                    load       = 1'b1;
                    credit_nxt = credit_q - CREDIT_W'(1);
                end else begin
                    state_nxt = COLLECT;
                end
            end
            REFUND: begin
                rej_nxt = (bus.coin != COIN_NONE);
                if (chg_done) begin
                    state_nxt = COLLECT;
                end else begin
                    credit_nxt = credit_q - CREDIT_W'(1);
                end
            end
            default: state_nxt = COLLECT;
        endcase
        busy_nxt = (state_nxt != COLLECT);
    end

    vend_change_out #(.W(CREDIT_W)) u_change (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .load     (load),
        .load_val (credit_q),
        .change   (chg_pulse),
        .done     (chg_done)
    );

    assign bus.sell     = sell_q;
    assign bus.change   = chg_pulse;
    assign bus.coin_rej = rej_q;
    assign bus.busy     = busy_q;
    assign bus.credit   = credit_q;
    assign bus.sold_cnt = sold_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Randomised bench for vend_fsm_param: a schedule-based model predicts every output per clock edge.
module tb_vend_fsm_param;

    localparam int PRICE = 3;
    localparam int MAXE  = 4096;
`ifdef VEND_REFUND_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    vend_fsm_param_if #(.CREDIT_W(4), .CNT_W(8)) bus_a ();
    vend_fsm_param_if #(.CREDIT_W(4), .CNT_W(2)) bus_b ();

    vend_fsm_param #(.PRICE(PRICE), .CREDIT_W(4), .CNT_W(8)) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_a)
    );

    vend_fsm_param #(.PRICE(PRICE), .CREDIT_W(4), .CNT_W(2)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    // expected outputs after clock edge n (index = edge number since last reset release)
    bit e_sell[MAXE], e_change[MAXE], e_busy[MAXE], e_rej[MAXE];
    int e_credit[MAXE], e_sales[MAXE];

    int cr      = 0;  // credit collected toward the next sale
    int sales   = 0;
    int free_at = 0;  // first edge at which the machine is collecting again
    int n_next  = 0;
    int n_done  = -1;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_edge(input int n, input int c, input bit k);
        int ch;
        e_rej[n] = 1'b0;
        if (n < free_at) begin
            e_rej[n] = (c != 0);
        end else if (CANCEL_EN && k) begin
            e_rej[n]    = (c != 0);
            e_credit[n] = 0;
            for (int j = 0; j < cr; j++) begin
                e_change[n+j] = 1'b1;
                e_busy[n+j]   = 1'b1;
                e_credit[n+j] = cr - 1 - j;
            end
            if (cr > 0) free_at = n + cr + 1;
            cr = 0;
        end else if (c == 3) begin
            e_rej[n]    = 1'b1;
            e_credit[n] = cr;
        end else if (c != 0) begin
            if (cr + c >= PRICE) begin
                ch = cr + c - PRICE;
                sales++;
                e_sell[n] = 1'b1;
                for (int j = 0; j <= ch; j++) begin
                    e_busy[n+j]   = 1'b1;
                    e_credit[n+j] = ch - j;
                end
                for (int j = 1; j <= ch; j++) e_change[n+j] = 1'b1;
                free_at = n + ch + 2;
                cr = 0;
            end else begin
                cr = cr + c;
                e_credit[n] = cr;
            end
        end else begin
            e_credit[n] = cr;
        end
        e_sales[n] = sales;
    endfunction

    function automatic void model_reset();
        for (int i = n_next; i < MAXE; i++) begin
            e_sell[i] = 1'b0; e_change[i] = 1'b0; e_busy[i] = 1'b0;
            e_rej[i] = 1'b0; e_credit[i] = 0; e_sales[i] = 0;
        end
        cr = 0;
        sales = 0;
        free_at = n_next;
        n_done = -1;
    endfunction

    task automatic step(input int c, input bit k);
        bus_a.coin = c[1:0]; bus_b.coin = c[1:0];
        bus_a.cancel = k;    bus_b.cancel = k;
        model_edge(n_next, c, k);
        @(posedge sys_clk);
        n_done = n_next;
        n_next++;
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sell"},   int'(bus_a.sell), 0);
        chk({tag, "_change"}, int'(bus_a.change), 0);
        chk({tag, "_rej"},    int'(bus_a.coin_rej), 0);
        chk({tag, "_busy"},   int'(bus_a.busy), 0);
        chk({tag, "_credit"}, int'(bus_a.credit), 0);
        chk({tag, "_sold"},   int'(bus_a.sold_cnt), 0);
        chk({tag, "_sold_b"}, int'(bus_b.sold_cnt), 0);
    endtask

    always @(negedge sys_clk) begin
        int n;
        if (chk_en && n_done >= 0) begin
            n = n_done;
            chk($sformatf("sell@%0d", n),   int'(bus_a.sell),     int'(e_sell[n]));
            chk($sformatf("change@%0d", n), int'(bus_a.change),   int'(e_change[n]));
            chk($sformatf("rej@%0d", n),    int'(bus_a.coin_rej), int'(e_rej[n]));
            chk($sformatf("busy@%0d", n),   int'(bus_a.busy),     int'(e_busy[n]));
            chk($sformatf("credit@%0d", n), int'(bus_a.credit),   e_credit[n]);
            chk($sformatf("sold@%0d", n),   int'(bus_a.sold_cnt), min_i(e_sales[n], 255));
            chk($sformatf("sold_b@%0d", n), int'(bus_b.sold_cnt), min_i(e_sales[n], 3));
            chk($sformatf("change_b@%0d", n), int'(bus_b.change), int'(e_change[n]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r;
        bus_a.coin = 2'd0; bus_b.coin = 2'd0;
        bus_a.cancel = 1'b0; bus_b.cancel = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        chk_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chk_en = 1'b1;

        // exact price from 1 then 2
        step(1, 0);
        step(2, 0);
        chk("lit_sell_1_2", int'(bus_a.sell), 1);
        chk("lit_credit_1_2", int'(bus_a.credit), 0);
        chk("lit_sold_1_2", int'(bus_a.sold_cnt), 1);
        chk("model_sell_1_2", int'(e_sell[n_done]), 1);
        step(0, 0);
        chk("lit_nochange_1_2", int'(bus_a.change), 0);
        step(0, 0);

        // overpay 2+2: one change pulse, then a coin sampled in REFUND is rejected
        step(2, 0);
        step(2, 0);
        chk("lit_sell_2_2", int'(bus_a.sell), 1);
        chk("lit_credit_2_2", int'(bus_a.credit), 1);
        step(0, 0);
        chk("lit_change_2_2", int'(bus_a.change), 1);
        chk("lit_credit0_2_2", int'(bus_a.credit), 0);
        chk("model_change_2_2", int'(e_change[n_done]), 1);
        step(1, 0);
        chk("lit_rej_refund", int'(bus_a.coin_rej), 1);
        chk("lit_change_done", int'(bus_a.change), 0);
        step(0, 0);

        // illegal coin leaves credit alone
        step(1, 0);
        step(3, 0);
        chk("lit_rej_bad", int'(bus_a.coin_rej), 1);
        chk("lit_credit_bad", int'(bus_a.credit), 1);

        // cancel with one unit of credit
        step(0, 1);
`ifdef VEND_REFUND_EN
        chk("lit_cancel_change", int'(bus_a.change), 1);
        chk("lit_cancel_credit", int'(bus_a.credit), 0);
`else
        chk("lit_cancel_change", int'(bus_a.change), 0);
        chk("lit_cancel_credit", int'(bus_a.credit), 1);
`endif
        chk("lit_cancel_nosell", int'(bus_a.sell), 0);
        step(0, 0);
        step(0, 0);
`ifndef VEND_REFUND_EN
        step(2, 0);
        step(0, 0);
        step(0, 0);
`endif

        // asynchronous reset in the middle of a change payout
        step(2, 0);
        step(2, 0);
        step(0, 0);
        chk("lit_pre_reset_change", int'(bus_a.change), 1);
        #1;
        chk_en = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        step(0, 0);
        chk("lit_post_rst_change", int'(bus_a.change), 0);
        chk("lit_post_rst_credit", int'(bus_a.credit), 0);
        step(0, 0);

        // four sales saturate the 2-bit counter
        repeat (4) begin
            step(1, 0);
            step(2, 0);
            step(0, 0);
        end
        chk("lit_sat_b", int'(bus_b.sold_cnt), 3);
        chk("lit_cnt_a", int'(bus_a.sold_cnt), 4);

        // randomised traffic
        repeat (1500) begin
            r = $urandom_range(0, 9);
            c = (r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            step(c, ($urandom_range(0, 9) == 0));
        end
        repeat (6) step(0, 0);
        @(negedge sys_clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending-machine controller, the successor to the fixed-price coin FSM used in the lab designs. It accumulates coin credit up to a configurable price and pulses `sell` once. It then returns any overpayment as a train of single-unit `change` pulses, and optionally refunds the full credit on `cancel`. It sits between the coin-acceptor interface (debounced, one-cycle coin codes) and the dispense/change actuator drivers.

## Interface
- `PRICE`, default 3: item price in coin units (1 unit = smallest coin); must be ≥ 1.
- `CREDIT_W`, default 4: credit register width; requires 2^CREDIT_W > PRICE+1.
- `CNT_W`, default 8: width of the sold-item counter.
- `sys_clk` in 1: system clock, rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `coin` in 2: coin code, valid for one cycle. 0 = none, 1 = 1 unit, 2 = 2 units, 3 = illegal.
- `cancel` in 1: refund request, level-sampled each cycle.
- `sell` out 1: one-cycle dispense pulse.
- `change` out 1: one-cycle pulse per unit of change returned.
- `coin_rej` out 1: one-cycle pulse when a coin is not credited.
- `busy` out 1: high in VEND and REFUND.
- `credit` out CREDIT_W: current credit in units.
- `sold_cnt` out CNT_W: saturating count of `sell` pulses.

## Operation
- States: COLLECT, VEND, REFUND. Reset state is COLLECT.
- Reset values: `credit`=0, `sold_cnt`=0, and `sell`, `change`, `coin_rej`, `busy` all 0.
- COLLECT, legal coin (1 or 2), no cancel:
  - sum = credit + value.
  - If sum ≥ PRICE: credit ← sum − PRICE, go to VEND.
  - Otherwise: credit ← sum, stay in COLLECT.
- COLLECT, coin 3: not credited, `coin_rej` pulse, state unchanged.
- VEND: `sell`=1 for exactly one cycle and `sold_cnt` increments, saturating at all-ones. Next state is REFUND if credit > 0, else COLLECT.
- REFUND: `change`=1 every cycle and credit decrements by 1 each cycle. On the cycle the credit reaches 0, return to COLLECT. Total change pulses equal the credit on entry.
- Any nonzero `coin` in VEND or REFUND: not credited, `coin_rej` pulse. `cancel` is ignored in VEND and REFUND.
- Cancel (only with `VEND_REFUND_EN`):
  - In COLLECT with credit > 0: go to REFUND with the current credit.
  - In COLLECT with credit 0: no-op.
  - Simultaneous coin and cancel in COLLECT: cancel wins; a nonzero coin is rejected (`coin_rej`) and is not refunded.
- Arithmetic: the sum is computed at CREDIT_W+1 bits. The parameter constraint guarantees no overflow.
- Reset during any state returns immediately to COLLECT with credit discarded. No change is owed after reset.

## Timing
- All outputs are registered.
- A coin sampled at edge N that reaches the price gives `sell` high during cycle N+1.
- The first `change` pulse follows in cycle N+2. The k-th change pulse is in cycle N+1+k.
- `coin_rej` is high in the cycle after the offending sample.
- A cancel sampled at edge N gives the first `change` pulse in cycle N+1.
- `credit` reflects the post-edge value, so it decrements in step with `change`.
- Back-to-back coins are accepted every cycle in COLLECT. There is no handshake; the upstream acceptor must not resend a rejected coin.

## Configuration
- `VEND_REFUND_EN` defined: `cancel` triggers a full refund as described above.
- `VEND_REFUND_EN` undefined: `cancel` is ignored in all states and simultaneous coin+cancel is treated as coin only. REFUND is still used for overpayment change.

## Structure
- Package `vend_pkg`: state enum (COLLECT, VEND, REFUND) and coin code constants (COIN_NONE=0, COIN_ONE=1, COIN_TWO=2, COIN_BAD=3).
- One sub-module `vend_change_out`: loadable down-counter that emits one `change` pulse per cycle while nonzero and signals done. The top FSM loads it on entry to REFUND.

## Test plan
All scenarios use PRICE=3.
- Coins 1 then 2 on consecutive cycles → `sell` for 1 cycle, no `change`, `credit`=0, `sold_cnt`=1.
- Coins 2, 2 → `sell` in cycle N+1, exactly one `change` pulse in N+2, `credit` returns to 0.
- Coin 1, then `cancel` (macro on) → one `change` pulse, no `sell`, `sold_cnt` unchanged. With macro off → no `change`, `credit` stays 1.
- Coin 3 in COLLECT → `coin_rej` pulse, `credit` unchanged. Coin 1 during REFUND → `coin_rej` pulse, change count unaffected.
- CNT_W=2: four complete sales → `sold_cnt` saturates at 3.
- Reset asserted mid-REFUND → all outputs 0 asynchronously. After release, state is COLLECT, `credit`=0 and no further `change` pulses occur.
